// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage MIPS pipeline: little-endian data memory with byte/half/word
// loads and stores, a fixed number of wait states per access, and upstream stall generation.
module mem_access_stage #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wregin,
  input  logic        m2regin,
  input  logic        wmemin,
  input  logic [1:0]  sizein,
  input  logic        unsignedin,
  input  logic [4:0]  RdRtin,
  input  logic [31:0] aluresultin,
  input  logic [31:0] storedatain,
  output logic        wregout,
  output logic        m2regout,
  output logic [4:0]  RdRtout,
  output logic [31:0] aluresultout,
  output logic [31:0] memdataout,
  output logic        stall,
  output logic        misalign
);

  localparam int       LP_DEPTH    = 1 << ADDR_WIDTH;
  localparam bit       LP_HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [2:0] LP_CNT_INIT = LP_HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t          r_state;
  logic [2:0]      r_cnt;
  logic [31:0]     r_mem [LP_DEPTH];

  logic                  w_access;
  logic                  w_misalign;
  logic                  w_aligned;
  logic                  w_stall;
  logic                  w_complete;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_ext;

  assign w_access = m2regin | wmemin;
  assign w_idx    = aluresultin[ADDR_WIDTH+1:2];
  assign w_off    = aluresultin[1:0];

  // Size 2'b11 decodes as a word through sizein[1].
  always_comb begin
    w_misalign = 1'b0;
    if (w_access) begin
      if (sizein == 2'b01)
        w_misalign = w_off[0];
      else if (sizein[1])
        w_misalign = (w_off != 2'b00);
    end
  end

  assign w_aligned = w_access & ~w_misalign;

  always_comb begin
    w_stall = 1'b0;
    if (r_state == ST_IDLE)
      w_stall = w_aligned & LP_HAS_WAIT;
    else
      w_stall = (r_cnt != '0);
  end

  assign w_complete = w_aligned & ~w_stall;
  assign w_we       = clrn & w_complete & wmemin;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aligned && LP_HAS_WAIT) begin
            r_state <= ST_WAIT;
            r_cnt   <= LP_CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0)
            r_cnt <= r_cnt - 3'd1;
          else
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = storedatain;
    case (sizein)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{storedatain[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{storedatain[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = storedatain;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ext = w_word;
    case (sizein)
      2'b00:   w_ext = unsignedin ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = unsignedin ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = w_word;
    endcase
  end

  assign wregout      = clrn & wregin  & ~w_stall & ~w_misalign;
  assign m2regout     = clrn & m2regin & ~w_stall & ~w_misalign;
  assign RdRtout      = clrn ? RdRtin      : '0;
  assign aluresultout = clrn ? aluresultin : '0;
  assign memdataout   = clrn ? w_ext       : '0;
  assign stall        = clrn & w_stall;
  assign misalign     = clrn & w_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: three instances (0, 1 and 2 wait states) share one input
// bundle; only the instance under test is out of reset, so the others never write memory.
module tb_mem_access_stage;

  logic        clk;
  logic [2:0]  clrn;
  logic        wregin;
  logic        m2regin;
  logic        wmemin;
  logic [1:0]  sizein;
  logic        unsignedin;
  logic [4:0]  RdRtin;
  logic [31:0] aluresultin;
  logic [31:0] storedatain;

  logic [2:0]  wregout;
  logic [2:0]  m2regout;
  logic [4:0]  RdRtout      [3];
  logic [31:0] aluresultout [3];
  logic [31:0] memdataout   [3];
  logic [2:0]  stall;
  logic [2:0]  misalign;

  int n_checks;
  int n_errors;
  int sel;

  logic        s_wreg;
  logic        s_m2reg;
  logic [4:0]  s_rd;
  logic [31:0] s_alu;
  logic [31:0] s_mem;
  logic        s_stall;
  logic        s_mis;

  assign s_wreg  = wregout[sel];
  assign s_m2reg = m2regout[sel];
  assign s_rd    = RdRtout[sel];
  assign s_alu   = aluresultout[sel];
  assign s_mem   = memdataout[sel];
  assign s_stall = stall[sel];
  assign s_mis   = misalign[sel];

  mem_access_stage #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .clrn(clrn[0]), .wregin(wregin), .m2regin(m2regin), .wmemin(wmemin),
    .sizein(sizein), .unsignedin(unsignedin), .RdRtin(RdRtin), .aluresultin(aluresultin),
    .storedatain(storedatain), .wregout(wregout[0]), .m2regout(m2regout[0]),
    .RdRtout(RdRtout[0]), .aluresultout(aluresultout[0]), .memdataout(memdataout[0]),
    .stall(stall[0]), .misalign(misalign[0])
  );

  mem_access_stage #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .clrn(clrn[1]), .wregin(wregin), .m2regin(m2regin), .wmemin(wmemin),
    .sizein(sizein), .unsignedin(unsignedin), .RdRtin(RdRtin), .aluresultin(aluresultin),
    .storedatain(storedatain), .wregout(wregout[1]), .m2regout(m2regout[1]),
    .RdRtout(RdRtout[1]), .aluresultout(aluresultout[1]), .memdataout(memdataout[1]),
    .stall(stall[1]), .misalign(misalign[1])
  );

  mem_access_stage #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .clrn(clrn[2]), .wregin(wregin), .m2regin(m2regin), .wmemin(wmemin),
    .sizein(sizein), .unsignedin(unsignedin), .RdRtin(RdRtin), .aluresultin(aluresultin),
    .storedatain(storedatain), .wregout(wregout[2]), .m2regout(m2regout[2]),
    .RdRtout(RdRtout[2]), .aluresultout(aluresultout[2]), .memdataout(memdataout[2]),
    .stall(stall[2]), .misalign(misalign[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] sd);
    wregin      = wr;
    m2regin     = ld;
    wmemin      = st;
    sizein      = sz;
    unsignedin  = uns;
    RdRtin      = rd;
    aluresultin = addr;
    storedatain = sd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One aligned load (ld=1) or store (ld=0) with w expected stall cycles, then completion.
  task automatic access(input string tag, input int w, input logic ld, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] exp);
    drive(ld, ld, ~ld, sz, uns, 5'd9, addr, sd);
    for (int c = 0; c < w; c++) begin
      @(negedge clk);
      check({tag, "/stall"}, 32'(s_stall), 32'd1);
      check({tag, "/wreg_bubble"}, 32'(s_wreg), 32'd0);
      check({tag, "/m2reg_bubble"}, 32'(s_m2reg), 32'd0);
      step();
    end
    @(negedge clk);
    check({tag, "/stall_done"}, 32'(s_stall), 32'd0);
    check({tag, "/misalign"}, 32'(s_mis), 32'd0);
    check({tag, "/wreg"}, 32'(s_wreg), 32'(ld));
    check({tag, "/m2reg"}, 32'(s_m2reg), 32'(ld));
    check({tag, "/alu"}, s_alu, addr);
    check({tag, "/rd"}, 32'(s_rd), 32'd9);
    if (ld)
      check({tag, "/data"}, s_mem, exp);
    step();
  endtask

  task automatic misaligned(input string tag, input logic ld, input logic [1:0] sz,
                            input logic [31:0] addr);
    drive(1'b1, ld, ~ld, sz, 1'b0, 5'd4, addr, 32'hFFFF_FFFF);
    @(negedge clk);
    check({tag, "/misalign"}, 32'(s_mis), 32'd1);
    check({tag, "/stall"}, 32'(s_stall), 32'd0);
    check({tag, "/wreg"}, 32'(s_wreg), 32'd0);
    check({tag, "/m2reg"}, 32'(s_m2reg), 32'd0);
    step();
  endtask

  task automatic reset_outputs_zero(input string tag);
    @(negedge clk);
    check({tag, "/wreg"}, 32'(s_wreg), 32'd0);
    check({tag, "/m2reg"}, 32'(s_m2reg), 32'd0);
    check({tag, "/rd"}, 32'(s_rd), 32'd0);
    check({tag, "/alu"}, s_alu, 32'd0);
    check({tag, "/mem"}, s_mem, 32'd0);
    check({tag, "/stall"}, 32'(s_stall), 32'd0);
    check({tag, "/misalign"}, 32'(s_mis), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    sel      = 2;
    clrn     = 3'b000;
    drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    step();

    // Two wait states: reset with a store held, release, mid-WAIT abort.
    clrn[2] = 1'b1;
    access("w2_store_init", 2, 1'b0, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 32'd0);
    clrn[2] = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 5'd9, 32'h40, 32'h1122_3344);
    reset_outputs_zero("rst_hold_a");
    step();
    reset_outputs_zero("rst_hold_b");
    step();
    clrn[2] = 1'b1;
    access("rst_nowrite_load", 2, 1'b1, 2'b10, 1'b0, 32'h40, 32'd0, 32'hCAFE_F00D);
    clrn[2] = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 5'd9, 32'h40, 32'h1122_3344);
    step();
    clrn[2] = 1'b1;
    access("rst_release_store", 2, 1'b0, 2'b10, 1'b0, 32'h40, 32'h1122_3344, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 5'd9, 32'h40, 32'h5555_5555);
    @(negedge clk);
    check("mid_wait/stall", 32'(s_stall), 32'd1);
    step();
    clrn[2] = 1'b0;
    reset_outputs_zero("mid_wait_rst");
    step();
    drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0, 32'h0, 32'h0);
    clrn[2] = 1'b1;
    @(negedge clk);
    check("mid_wait/idle_nop", 32'(s_stall), 32'd0);
    step();
    access("mid_wait_load", 2, 1'b1, 2'b10, 1'b0, 32'h40, 32'd0, 32'h1122_3344);
    clrn[2] = 1'b0;

    // One wait state: word, byte and half lanes, misalign, wrap-around, non-access.
    sel     = 1;
    clrn[1] = 1'b1;
    access("w_store", 1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'd0);
    access("w_load", 1, 1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF);
    access("lane_store", 1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01, 32'd0);
    access("sb_23", 1, 1'b1, 2'b00, 1'b0, 32'h23, 32'd0, 32'hFFFF_FF80);
    access("ub_23", 1, 1'b1, 2'b00, 1'b1, 32'h23, 32'd0, 32'h0000_0080);
    access("sb_21", 1, 1'b1, 2'b00, 1'b0, 32'h21, 32'd0, 32'h0000_007F);
    access("sh_22", 1, 1'b1, 2'b01, 1'b0, 32'h22, 32'd0, 32'hFFFF_80FF);
    access("uh_20", 1, 1'b1, 2'b01, 1'b1, 32'h20, 32'd0, 32'h0000_7F01);
    access("sb_store_21", 1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h1234_56AA, 32'd0);
    access("after_sb", 1, 1'b1, 2'b10, 1'b0, 32'h20, 32'd0, 32'h80FF_AA01);
    access("sh_store_22", 1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 32'd0);
    access("after_sh", 1, 1'b1, 2'b11, 1'b0, 32'h20, 32'd0, 32'hBEEF_AA01);
    access("mis_init", 1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0BAD_F00D, 32'd0);
    misaligned("mis_lh_31", 1'b1, 2'b01, 32'h31);
    misaligned("mis_sw_32", 1'b0, 2'b10, 32'h32);
    access("mis_intact", 1, 1'b1, 2'b10, 1'b0, 32'h30, 32'd0, 32'h0BAD_F00D);
    access("wrap_store", 1, 1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h1357_2468, 32'd0);
    access("wrap_load", 1, 1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'd0, 32'h1357_2468);
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 5'd3, 32'h0000_1234, 32'd0);
    @(negedge clk);
    check("nop/stall", 32'(s_stall), 32'd0);
    check("nop/wreg", 32'(s_wreg), 32'd1);
    check("nop/alu", s_alu, 32'h0000_1234);
    check("nop/rd", 32'(s_rd), 32'd3);
    step();
    clrn[1] = 1'b0;

    // Zero wait states: one access per cycle, never stalling.
    sel     = 0;
    clrn[0] = 1'b1;
    access("z_store_8", 0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0102_0304, 32'd0);
    access("z_store_c", 0, 1'b0, 2'b10, 1'b0, 32'h0C, 32'hA0B0_C0D0, 32'd0);
    access("z_load_8", 0, 1'b1, 2'b10, 1'b0, 32'h08, 32'd0, 32'h0102_0304);
    access("z_load_c", 0, 1'b1, 2'b10, 1'b0, 32'h0C, 32'd0, 32'hA0B0_C0D0);
    access("z_lb_e", 0, 1'b1, 2'b00, 1'b0, 32'h0E, 32'd0, 32'hFFFF_FFB0);
    clrn[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the five-stage MIPS datapath. Sits between the EX/MEM pipeline register and the MEM/WB register. Holds the data memory and performs byte/halfword/word loads and stores with configurable wait states. Stalls upstream while an access is in flight, and hands MEM/WB either a completed result or a bubble.

## Interface
- ADDR_WIDTH, 8, word-address bits of data memory (2^ADDR_WIDTH 32-bit words)
- WAIT_CYCLES, 1, extra cycles per load/store, legal range 0..7

- clk  in  1  clock; all state updates on posedge
- clrn  in  1  reset, asynchronous, active-low
- wregin  in  1  instruction writes register file
- m2regin  in  1  instruction is a load
- wmemin  in  1  instruction is a store
- sizein  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
- unsignedin  in  1  load zero-extends (1) or sign-extends (0)
- RdRtin  in  5  destination register number
- aluresultin  in  32  ALU result; this is the byte address for loads and stores
- storedatain  in  32  store data (rt value); low bits are used for byte and half stores
- wregout  out  1  register write enable to MEM/WB
- m2regout  out  1  load-select to MEM/WB
- RdRtout  out  5  destination register to MEM/WB
- aluresultout  out  32  ALU result to MEM/WB
- memdataout  out  32  extended load data to MEM/WB
- stall  out  1  hold PC, IF/ID and EX/MEM; inputs must stay stable while high
- misalign  out  1  current access is misaligned and has been suppressed

## Operation
- An access is defined as `access = m2regin | wmemin`. If both are high, the instruction is a store.
- Word index is aluresultin[ADDR_WIDTH+1:2]. Higher address bits are ignored, so the memory wraps around.
- Byte lanes are little-endian: byte offset k selects bits 8k+7:8k.
  - Half at offset 0 selects bits 15:0; half at offset 2 selects bits 31:16.
- Misaligned accesses:
  - Half: aluresultin[0]=1.
  - Word: aluresultin[1:0]≠0.
  - Result: misalign=1, no write, wregout=0, m2regout=0, stall=0, and the FSM stays in IDLE.
- Stores write only the addressed lanes: a byte store writes 1 lane, a half store 2 lanes, a word store all 4.
- Loads extract the addressed lane(s), then zero- or sign-extend per unsignedin. A word load passes through unchanged.
- Memory read is combinational from the array. Memory contents are not reset.
- FSM has 2 states and a 3-bit counter cnt:
  - IDLE:
    - Aligned access with WAIT_CYCLES>0: stall=1, load cnt=WAIT_CYCLES-1, go to WAIT.
    - Aligned access with WAIT_CYCLES=0: complete in this cycle.
    - Otherwise: pass through.
  - WAIT, cnt≠0: stall=1, decrement cnt.
  - WAIT, cnt=0: stall=0, access completes (store commits at this posedge, load data valid), go to IDLE.
- While stall=1, outputs are a bubble: wregout=0, m2regout=0, no memory write. The other outputs are don't-care.
- When not stalled and not misaligned, wregout, m2regout, RdRtout and aluresultout equal their inputs.
- Non-access instructions (wmemin=m2regin=0) never stall.

## Timing
- Reset (clrn=0, asynchronous):
  - State is forced to IDLE and cnt=0.
  - All outputs are forced to 0 while clrn=0.
  - Reset during WAIT abandons the access: no write occurs.
- Latency:
  - An aligned access occupies the stage for WAIT_CYCLES+1 cycles, with stall high for exactly WAIT_CYCLES of them.
  - A non-access or misaligned instruction takes 1 cycle.
- Back-to-back accesses: the completion cycle returns the FSM to IDLE. The next access, presented on the following cycle, starts a fresh wait sequence with no extra dead cycle.
- All outputs are combinational from the inputs, the state and the memory. MEM/WB captures them at the posedge where stall=0.
- Store commit and the FSM transition to IDLE occur on the same posedge. A load of the same word on the next cycle sees the new data.

## Test plan
- Reset, WAIT_CYCLES=2:
  - Hold clrn=0 with wmemin=1 → all outputs 0, no write.
  - Release clrn → stall high for 2 cycles, then completes.
- Word store then load, WAIT_CYCLES=1:
  - Store 0xDEADBEEF to address 0x10 → stall 1 cycle, write on the 2nd cycle.
  - Load from 0x10 → memdataout=0xDEADBEEF, m2regout=1 on the completion cycle, wregout=0 during the stall.
- Byte/half lanes, with word 0x80FF7F01 stored at 0x20:
  - Signed byte at 0x23 → 0xFFFFFF80.
  - Unsigned byte at 0x23 → 0x00000080.
  - Signed half at 0x22 → 0xFFFF80FF.
  - Byte store of 0xAA at 0x21 then word load → 0x80FFAA01.
- Misalign:
  - Half load at 0x31 and word store at 0x32 → misalign=1, stall=0, wregout=0.
  - The word at 0x30 is unchanged.
- Wrap-around, ADDR_WIDTH=8:
  - Store to 0x00000404 → load from 0x00000004 returns the same data.
- Timing and stall behaviour:
  - WAIT_CYCLES=0: consecutive loads complete 1 per cycle with stall=0.
  - Reset asserted mid-WAIT of a store: memory is unchanged, FSM is in IDLE.
